// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU sharing arbiter: opcodes, NZCV flags and slot state.
package alu_arb_pkg;

    localparam int unsigned MAX_NREQ = 16;
    localparam int unsigned DW       = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_ORR = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu.sv
// 32-bit ALU: ADD/SUB/AND/ORR with NZCV flags; SUB carry is NOT borrow.
module alu
    import alu_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] result,
    output nzcv_t       flags
);

    logic [32:0] sum;
    logic [31:0] b_eff;

    // Subtraction is a + ~b + 1 so carry-out directly gives NOT borrow
    always_comb begin
        b_eff  = (op == OP_SUB) ? ~b : b;
        sum    = 33'(a) + 33'(b_eff) + 33'(op == OP_SUB);
        result = '0;
        flags  = '0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                result  = sum[31:0];
                flags.c = sum[32];
                flags.v = (a[31] == b_eff[31]) && (sum[31] != a[31]);
            end
            OP_AND: result = a & b;
            OP_ORR: result = a | b;
            default: result = '0;
        endcase
        flags.n = result[31];
        flags.z = (result == '0);
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, priority starting after last_grant.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant
);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last_grant) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grant and a one-entry response slot.
// Optional grant locking is enabled by defining ALU_ARB_LOCK_EN.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0]  req_op,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NREQ-1:0]    req_lock,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_result,
    output logic [3:0]         rsp_flags
);

    slot_state_t     state;
    logic [IDW-1:0]  last_grant;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            can_accept;
    logic            accept;
    logic [IDW-1:0]  sel;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [1:0]      alu_op_raw;
    logic [31:0]     alu_result;
    nzcv_t           alu_flags;

    assign rsp_valid  = (state == SLOT_FULL);
    assign can_accept = !rsp_valid || rsp_ready;

`ifdef ALU_ARB_LOCK_EN
    logic           locked;
    logic [IDW-1:0] lock_owner;

    // While locked, only the owner may compete for the ALU
    assign eligible = locked ? (req_valid & (NREQ'(1) << lock_owner)) : req_valid;
`else
    assign eligible = req_valid;
`endif

    alu_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_valid  (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Nothing is offered while reset is held, so no requester believes a lost op was taken
    assign req_ready = (can_accept && !reset) ? grant : '0;
    assign accept    = |req_ready;

    // Encode the one-hot grant and steer the winner's operands to the ALU
    always_comb begin
        sel        = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op_raw = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel        = IDW'(i);
                alu_a      = req_a[32*i +: 32];
                alu_b      = req_b[32*i +: 32];
                alu_op_raw = req_op[2*i +: 2];
            end
        end
    end

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op_t'(alu_op_raw)),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Response slot FSM plus payload and rotation pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SLOT_EMPTY;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            last_grant <= IDW'(NREQ - 1);
`ifdef ALU_ARB_LOCK_EN
            locked     <= 1'b0;
            lock_owner <= '0;
`endif
        end else begin
            unique case (state)
                SLOT_EMPTY: if (accept) state <= SLOT_FULL;
                SLOT_FULL:  if (rsp_ready && !accept) state <= SLOT_EMPTY;
                default:    state <= SLOT_EMPTY;
            endcase
            if (accept) begin
                rsp_id     <= sel;
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                last_grant <= sel;
`ifdef ALU_ARB_LOCK_EN
                locked     <= req_lock[sel];
                if (req_lock[sel]) lock_owner <= sel;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter; lock scenario runs when ALU_ARB_LOCK_EN is defined.
module tb_alu_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, ORR = 2'b11;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*2-1:0]  req_op;
    logic [NREQ-1:0]    req_lock;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [31:0]        rsp_result;
    logic [3:0]         rsp_flags;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] lk_a   [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
    logic        lk_lock[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  lk_rdy [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
`ifdef ALU_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] op);
        req_valid[i]     = v;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[2*i +: 2]  = op;
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] res, input logic [3:0] fl);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.fl  = fl;
        sb.push_back(e);
    endtask

    // Monitor: every completed response transfer is checked against the oldest expectation
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d result=0x%08h, none expected", rsp_id, rsp_result);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_flags", 32'(rsp_flags), 32'(mon_e.fl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_lock  = '0;
        rsp_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        // single ADD from req0
        tick();
        push(2'd0, 32'd13, 4'b0000);
        set_req(0, 1'b1, 32'h0000000A, 32'h00000003, ADD);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, 32'h0000000A, 32'h00000003, ADD);
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("t1_drained", 32'(rsp_valid), 32'd0);
        chk("t1_payload_kept", rsp_result, 32'd13);

        // single SUB from req2 with borrow
        tick();
        push(2'd2, 32'hFFFFFFF9, 4'b1000);
        set_req(2, 1'b1, 32'h3, 32'hA, SUB);
        @(negedge clk);
        chk("t2_ready", 32'(req_ready), 32'b0100);
        tick();
        set_req(2, 1'b0, 32'h3, 32'hA, SUB);
        @(negedge clk);
        chk("t2_valid", 32'(rsp_valid), 32'd1);
        tick();

        // all four requesters valid back to back after a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(2'd0, 32'd12, 4'b0000);
        push(2'd1, 32'd0, 4'b0110);
        push(2'd2, 32'hF000F000, 4'b1000);
        push(2'd3, 32'h80000001, 4'b1000);
        push(2'd0, 32'd12, 4'b0000);
        set_req(0, 1'b1, 32'd5, 32'd7, ADD);
        set_req(1, 1'b1, 32'd7, 32'd7, SUB);
        set_req(2, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, AND_);
        set_req(3, 1'b1, 32'h80000000, 32'h00000001, ORR);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k > 0) chk("t3_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("t3_last_valid", 32'(rsp_valid), 32'd1);
        tick();

        // stall for three cycles, then drain and accept together
        push(2'd1, 32'h80000000, 4'b1001);
        push(2'd3, 32'h00000000, 4'b0110);
        set_req(1, 1'b1, 32'h7FFFFFFF, 32'h00000001, ADD);
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 32'b0010);
        tick();
        rsp_ready = 1'b0;
        set_req(1, 1'b0, 32'h7FFFFFFF, 32'h00000001, ADD);
        set_req(3, 1'b1, 32'hFFFFFFFF, 32'h00000001, ADD);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_valid", 32'(rsp_valid), 32'd1);
            chk("t4_stall_id", 32'(rsp_id), 32'd1);
            chk("t4_stall_result", rsp_result, 32'h80000000);
            chk("t4_stall_flags", 32'(rsp_flags), 32'b1001);
            chk("t4_stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_ready", 32'(req_ready), 32'b1000);
        tick();
        set_req(3, 1'b0, 32'hFFFFFFFF, 32'h00000001, ADD);
        @(negedge clk);
        chk("t4_no_bubble", 32'(rsp_valid), 32'd1);
        tick();

        // reset while a response is held and requests are pending
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 32'd1, 32'd1, ADD);
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 32'b0100);
        tick();
        set_req(2, 1'b0, 32'd1, 32'd1, ADD);
        set_req(0, 1'b1, 32'd1, 32'd2, SUB);
        set_req(3, 1'b1, 32'hFFFF0000, 32'h0000FFFF, AND_);
        @(negedge clk);
        chk("t5_held", 32'(rsp_valid), 32'd1);
        chk("t5_stall_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_sync_reset", 32'(rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5_rst_id", 32'(rsp_id), 32'd0);
        tick();
        reset     = 1'b0;
        rsp_ready = 1'b1;
        push(2'd0, 32'hFFFFFFFF, 4'b1000);
        push(2'd3, 32'h00000000, 4'b0100);
        @(negedge clk);
        chk("t5_first_after_rst", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, 32'd1, 32'd2, SUB);
        @(negedge clk);
        chk("t5_second", 32'(req_ready), 32'b1000);
        tick();
        set_req(3, 1'b0, 32'hFFFF0000, 32'h0000FFFF, AND_);
        tick();

`ifdef ALU_ARB_LOCK_EN
        // req1 locks the ALU for three ops while req0 and req2 wait
        push(2'd0, 32'd2, 4'b0000);
        set_req(0, 1'b1, 32'd1, 32'd1, ADD);
        @(negedge clk);
        chk("t6_pre_ready", 32'(req_ready), 32'b0001);
        tick();
        push(2'd1, 32'd2, 4'b0000);
        push(2'd1, 32'd3, 4'b0000);
        push(2'd1, 32'd4, 4'b0000);
        push(2'd2, 32'd0, 4'b0100);
        set_req(2, 1'b1, 32'd0, 32'd0, ORR);
        for (int k = 0; k < 4; k++) begin
            set_req(1, (k < 3), lk_a[k], 32'd1, ADD);
            req_lock[1] = lk_lock[k];
            @(negedge clk);
            chk("t6_lock_ready", 32'(req_ready), 32'(lk_rdy[k]));
            tick();
        end
        req_valid = '0;
        req_lock  = '0;
        tick();
`endif

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
